// File: rtl/fetch_stage_pkg.sv
// ============================================================================
// fetch_stage_pkg : shared state encoding and constants for the fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_t;

   localparam logic [15:0] DEFAULT_NOP_INSTR   = 16'h0800;
   localparam logic [4:0]  DEFAULT_HALT_OPCODE = 5'b00000;

   function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
      return pc + 16'd2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_hold_buf.sv
// ============================================================================
// fetch_hold_buf : 32-bit {instr, pc} hold register with load and clear
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_hold_buf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] d,
   output logic [31:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (clear)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : WISC instruction fetch (PC, hold buffer, imem handshake, HALT)
// Optional macro FETCH_ALIGN_CHK_EN adds err_out for odd-PC fetches.  Rev 1.0
// ============================================================================
`default_nettype none

module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [15:0] NOP_INSTR   = DEFAULT_NOP_INSTR,
   parameter logic [4:0]  HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_in,
   input  logic        redirect_in,
   input  logic [15:0] redirect_pc_in,
   output logic        imem_req_out,
   output logic [15:0] imem_addr_out,
   input  logic [15:0] imem_data_in,
   input  logic        imem_rdy_in,
   output logic [15:0] instr_F_out,
   output logic [15:0] inc_PC_F_out,
   output logic        valid_F_out,
   output logic        halted_out
`ifdef FETCH_ALIGN_CHK_EN
   ,output logic       err_out
`endif
);

   fetch_state_t state;
   logic [15:0]  pc;
   logic         kill;
   logic [31:0]  hold_q;
   logic [15:0]  hold_instr;
   logic [15:0]  hold_pc;
   logic [15:0]  pc_inc;
   logic [15:0]  hold_pc_inc;
   logic         align_err;
   logic         fetch_active;
   logic         deliver;
   logic         hold_show;
   logic [15:0]  acc_instr;
   logic         is_halt;

   assign hold_instr  = hold_q[31:16];
   assign hold_pc     = hold_q[15:0];
   assign pc_inc      = pc_plus2(pc);
   assign hold_pc_inc = pc_plus2(hold_pc);

`ifdef FETCH_ALIGN_CHK_EN
   assign align_err = (state == ST_FETCH) && pc[0];
`else
   assign align_err = 1'b0;
`endif

   // Gating with rst_n drops the request the instant reset asserts, even mid-read.
   assign fetch_active = (state == ST_FETCH) && !align_err;
   assign imem_req_out = rst_n && (fetch_active || (state == ST_WAIT));
   assign imem_addr_out = pc;

   assign deliver   = rst_n && !redirect_in && imem_rdy_in &&
                      (fetch_active || ((state == ST_WAIT) && !kill));
   assign hold_show = rst_n && !redirect_in && (state == ST_HOLD);

   assign valid_F_out  = deliver || hold_show;
   assign instr_F_out  = deliver ? imem_data_in : (hold_show ? hold_instr  : NOP_INSTR);
   assign inc_PC_F_out = deliver ? pc_inc       : (hold_show ? hold_pc_inc : 16'h0000);
   assign halted_out   = (state == ST_HALT);

   assign acc_instr = deliver ? imem_data_in : hold_instr;
   assign is_halt   = (acc_instr[15:11] == HALT_OPCODE);

   fetch_hold_buf u_hold_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (deliver && stall_in),
      .clear (redirect_in),
      .d     ({imem_data_in, pc}),
      .q     (hold_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_FETCH;
         pc    <= RESET_PC;
         kill  <= 1'b0;
      end else if (redirect_in) begin
         pc <= redirect_pc_in;
         // An in-flight read cannot be aborted; mark it so its data is dropped.
         if ((state == ST_WAIT) && !imem_rdy_in) begin
            state <= ST_WAIT;
            kill  <= 1'b1;
         end else begin
            state <= ST_FETCH;
            kill  <= 1'b0;
         end
      end else begin
         case (state)
            ST_FETCH: begin
               if (align_err)         state <= ST_HALT;
               else if (!imem_rdy_in) state <= ST_WAIT;
               else if (stall_in)     state <= ST_HOLD;
               else if (is_halt)      state <= ST_HALT;
               else                   pc    <= pc_inc;
            end
            ST_WAIT: begin
               if (imem_rdy_in) begin
                  if (kill) begin
                     kill  <= 1'b0;
                     state <= ST_FETCH;
                  end else if (stall_in) begin
                     state <= ST_HOLD;
                  end else if (is_halt) begin
                     state <= ST_HALT;
                  end else begin
                     pc    <= pc_inc;
                     state <= ST_FETCH;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall_in) begin
                  if (is_halt) begin
                     pc    <= hold_pc;
                     state <= ST_HALT;
                  end else begin
                     pc    <= hold_pc_inc;
                     state <= ST_FETCH;
                  end
               end
            end
            ST_HALT: state <= ST_HALT;
            default: state <= ST_FETCH;
         endcase
      end
   end

`ifdef FETCH_ALIGN_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_out <= 1'b0;
      else if (!redirect_in && align_err)
         err_out <= 1'b1;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : scoreboard bench for fetch_stage with a latency-configurable
// instruction memory model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_in;
   logic        redirect_in;
   logic [15:0] redirect_pc_in;
   logic        imem_req_out;
   logic [15:0] imem_addr_out;
   logic [15:0] imem_data_in;
   logic        imem_rdy_in;
   logic [15:0] instr_F_out;
   logic [15:0] inc_PC_F_out;
   logic        valid_F_out;
   logic        halted_out;
`ifdef FETCH_ALIGN_CHK_EN
   logic        err_out;
`endif

   int          checks = 0;
   int          errors = 0;
   int          lat    = 0;
   int          wait_cnt = 0;
   logic [31:0] exp_q[$];

   fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall_in       (stall_in),
      .redirect_in    (redirect_in),
      .redirect_pc_in (redirect_pc_in),
      .imem_req_out   (imem_req_out),
      .imem_addr_out  (imem_addr_out),
      .imem_data_in   (imem_data_in),
      .imem_rdy_in    (imem_rdy_in),
      .instr_F_out    (instr_F_out),
      .inc_PC_F_out   (inc_PC_F_out),
      .valid_F_out    (valid_F_out),
      .halted_out     (halted_out)
`ifdef FETCH_ALIGN_CHK_EN
      ,.err_out       (err_out)
`endif
   );

   always #5 clk = ~clk;

   // Memory image: word at address a is 0x4000 + a/2 + 1, with a HALT at 0x004A.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == 16'h004A) return 16'h0000;
      return 16'h4000 + {1'b0, a[15:1]} + 16'd1;
   endfunction

   always @(posedge clk) begin
      if (!imem_req_out || imem_rdy_in) wait_cnt <= 0;
      else                              wait_cnt <= wait_cnt + 1;
   end

   assign imem_rdy_in  = imem_req_out && (wait_cnt >= lat);
   assign imem_data_in = imem_rdy_in ? mem_word(imem_addr_out) : 16'hDEAD;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive inputs, queue the expected output, check control outputs.
   task automatic cyc(input logic s, input logic r, input logic [15:0] rp,
                      input logic ev, input logic [15:0] ei, input logic [15:0] ep,
                      input logic er, input logic [15:0] ea, input logic eh);
      stall_in       = s;
      redirect_in    = r;
      redirect_pc_in = rp;
      if (ev) exp_q.push_back({ei, ep});
      @(negedge clk);
      chk("valid",  {15'd0, valid_F_out},  {15'd0, ev});
      chk("req",    {15'd0, imem_req_out}, {15'd0, er});
      chk("addr",   imem_addr_out, ea);
      chk("halted", {15'd0, halted_out},   {15'd0, eh});
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (valid_F_out) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got instr %h inc_pc %h expected none",
                        instr_F_out, inc_PC_F_out);
            end else begin
               e = exp_q.pop_front();
               chk("instr",  instr_F_out,  e[31:16]);
               chk("inc_pc", inc_PC_F_out, e[15:0]);
            end
         end else begin
            chk("nop_instr", instr_F_out,  16'h0800);
            chk("nop_inc",   inc_PC_F_out, 16'h0000);
         end
      end
   end

   initial begin : watchdog
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : stimulus
      rst_n = 1'b0; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = 16'h0000;
      lat = 0;
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 0,16'h0000,0);
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 0,16'h0000,0);
`ifdef FETCH_ALIGN_CHK_EN
      chk("err_reset", {15'd0, err_out}, 16'h0000);
`endif
      rst_n = 1'b1;
      // zero-wait stream, then a 2-cycle stall on the word at 0x0004
      cyc(0,0,16'h0000, 1,16'h4001,16'h0002, 1,16'h0000,0);
      cyc(0,0,16'h0000, 1,16'h4002,16'h0004, 1,16'h0002,0);
      cyc(1,0,16'h0000, 1,16'h4003,16'h0006, 1,16'h0004,0);
      cyc(1,0,16'h0000, 1,16'h4003,16'h0006, 0,16'h0004,0);
      lat = 3;
      cyc(0,0,16'h0000, 1,16'h4003,16'h0006, 0,16'h0004,0);
      // 3-cycle memory latency at 0x0006
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 1,16'h0006,0);
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 1,16'h0006,0);
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 1,16'h0006,0);
      cyc(0,0,16'h0000, 1,16'h4004,16'h0008, 1,16'h0006,0);
      // redirect to 0x0040 while the read at 0x0008 is outstanding
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 1,16'h0008,0);
      cyc(0,1,16'h0040, 0,16'h0000,16'h0000, 1,16'h0008,0);
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 1,16'h0040,0);
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 1,16'h0040,0);
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 1,16'h0040,0);
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 1,16'h0040,0);
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 1,16'h0040,0);
      cyc(1,0,16'h0000, 1,16'h4021,16'h0042, 1,16'h0040,0);
      lat = 0;
      cyc(0,0,16'h0000, 1,16'h4021,16'h0042, 0,16'h0040,0);
      // stream up to the HALT at 0x004A
      cyc(0,0,16'h0000, 1,16'h4022,16'h0044, 1,16'h0042,0);
      cyc(0,0,16'h0000, 1,16'h4023,16'h0046, 1,16'h0044,0);
      cyc(0,0,16'h0000, 1,16'h4024,16'h0048, 1,16'h0046,0);
      cyc(0,0,16'h0000, 1,16'h4025,16'h004A, 1,16'h0048,0);
      cyc(0,0,16'h0000, 1,16'h0000,16'h004C, 1,16'h004A,0);
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 0,16'h004A,1);
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 0,16'h004A,1);
      cyc(0,1,16'h0020, 0,16'h0000,16'h0000, 0,16'h004A,1);
      cyc(1,0,16'h0000, 1,16'h4011,16'h0022, 1,16'h0020,0);
      cyc(1,0,16'h0000, 1,16'h4011,16'h0022, 0,16'h0020,0);
      lat = 3;
      cyc(0,0,16'h0000, 1,16'h4011,16'h0022, 0,16'h0020,0);
      // stall while waiting has no effect; reset mid-read drops the request
      cyc(1,0,16'h0000, 0,16'h0000,16'h0000, 1,16'h0022,0);
      cyc(1,0,16'h0000, 0,16'h0000,16'h0000, 1,16'h0022,0);
      rst_n = 1'b0;
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 0,16'h0000,0);
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 0,16'h0000,0);
      rst_n = 1'b1;
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 1,16'h0000,0);
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 1,16'h0000,0);
`ifdef FETCH_ALIGN_CHK_EN
      rst_n = 1'b0;
      lat = 0;
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 0,16'h0000,0);
      rst_n = 1'b1;
      cyc(0,1,16'h0011, 0,16'h0000,16'h0000, 1,16'h0000,0);
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 0,16'h0011,0);
      cyc(0,0,16'h0000, 0,16'h0000,16'h0000, 0,16'h0011,1);
      chk("err_out", {15'd0, err_out}, 16'h0001);
`endif
      chk("queue_empty", exp_q.size()[15:0], 16'h0000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
